// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shifter: operation encodings,
// controller state type and a small mode classification helper.
package shifter_pkg;

    // Operation select encodings; 3'b101 to 3'b111 are reserved.
    typedef enum logic [2:0] {
        MODE_SLL = 3'b000,
        MODE_SRL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROL = 3'b011,
        MODE_ROR = 3'b100
    } mode_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // True when the encoding names a real shift/rotate operation.
    function automatic logic mode_is_shift(input logic [2:0] mode);
        return (mode <= 3'b100);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step: produces the value after a single-bit move
// and the bit that left the register during that move.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    // Select the one-bit move for the operation; reserved codes pass through.
    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (mode)
            MODE_SLL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                out_bit    = value[WIDTH-1];
            end
            MODE_SRL: begin
                next_value = {1'b0, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_SRA: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
            MODE_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shifter: moves the operand one bit per clock for shamt clocks,
// then publishes the result and the last bit shifted out with a done pulse.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out,
    output logic               carry_out
);

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_e             state_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [WIDTH-1:0]   work_r;
    logic [2:0]         mode_r;
    logic [WIDTH-1:0]   next_s;
    logic               out_bit_s;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode       (mode_r),
        .value      (work_r),
        .next_value (next_s),
        .out_bit    (out_bit_s)
    );

    // Controller: accepts work in IDLE/DONE, steps once per clock in SHIFT,
    // and only touches data_out/carry_out when entering DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            work_r    <= {WIDTH{1'b0}};
            mode_r    <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= {WIDTH{1'b0}};
            carry_out <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_r <= mode;
                        work_r <= data_in;
                        if ((shamt == CNT_ZERO) || !mode_is_shift(mode)) begin
                            // Nothing to move: result is the operand itself.
                            state_r   <= ST_DONE;
                            cnt_r     <= CNT_ZERO;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            data_out  <= data_in;
                            carry_out <= 1'b0;
                        end else begin
                            state_r <= ST_SHIFT;
                            cnt_r   <= shamt;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work_r <= next_s;
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r   <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        data_out  <= next_s;
                        carry_out <= out_bit_s;
                    end else begin
                        state_r <= ST_SHIFT;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width; legal values are powers of two, 4 or greater.
REQ-002 The module SHALL have parameter SHAMT_W, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 The module SHALL have port mode, input, 3 bits: operation select.
REQ-007 The module SHALL have port data_in, input, WIDTH bits: the operand.
REQ-008 The module SHALL have port shamt, input, SHAMT_W bits: the shift amount, 0 to WIDTH-1.
REQ-009 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The module SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-011 The module SHALL have port data_out, output, WIDTH bits: the result.
REQ-012 The module SHALL have port carry_out, output, 1 bit: the last bit shifted or rotated out.

Function
REQ-013 Mode encodings SHALL be: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101 to 111 reserved.
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE; all outputs SHALL be registered.
REQ-015 start SHALL be accepted only at a rising edge where state is IDLE or DONE; on acceptance, data_in, mode and shamt SHALL be latched.
REQ-016 start SHALL be ignored in SHIFT, with no effect on the operation in flight.
REQ-017 On acceptance with shamt=0 or a reserved mode, the next state SHALL be DONE, with data_out=data_in and carry_out=0.
REQ-018 Otherwise the next state SHALL be SHIFT, with the counter set to shamt.
REQ-019 In SHIFT, each edge SHALL shift the working register by exactly one bit and decrement the counter.
REQ-020 The shift edge on which the counter equals 1 SHALL transition to DONE and load data_out and carry_out.
REQ-021 Latency from the accepting edge to done=1 SHALL be max(shamt,1) cycles.
REQ-022 SLL and SRL SHALL fill with 0, SRA SHALL replicate the MSB, and ROL and ROR SHALL rotate bits around.
REQ-023 carry_out SHALL equal the bit that left the register on the final one-bit step.
REQ-024 busy SHALL be 1 exactly while state is SHIFT.
REQ-025 done SHALL be 1 exactly while state is DONE, which lasts one cycle.
REQ-026 From DONE, the FSM SHALL go to IDLE, or accept a new start on the same edge; this gives back-to-back operation with no idle bubble.
REQ-027 data_out and carry_out SHALL hold their values until the next entry to DONE; intermediate shift values SHALL NOT appear on data_out.

Reset
REQ-028 Asserting reset at any time SHALL immediately force state IDLE, busy=0, done=0, data_out=0, carry_out=0, counter=0 and working register=0.
REQ-029 Reset mid-operation SHALL abandon the operation, with no done pulse after release.
REQ-030 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-031 A shared package shifter_pkg SHALL hold the mode encodings (SLL, SRL, SRA, ROL, ROR) and the FSM state type.
REQ-032 The one-bit step logic SHALL be a combinational sub-module shift_step (inputs: mode and working value; outputs: next value and out-bit), instantiated once.
REQ-033 The implementation SHALL be within 120 to 400 lines of RTL.

Verification
REQ-034 A bench SHALL cover SLL, data_in=8'hB5, shamt=3 -> done exactly 3 cycles after acceptance, data_out=8'hA8, carry_out=1.
REQ-035 A bench SHALL cover SRA, data_in=8'h90, shamt=2 -> data_out=8'hE4, carry_out=0; and ROR, data_in=8'h01, shamt=1 -> data_out=8'h80, carry_out=1.
REQ-036 A bench SHALL cover shamt=0 and mode=3'b111 with data_in=8'h5A -> done 1 cycle after acceptance, data_out=8'h5A, carry_out=0, busy never 1.
REQ-037 A bench SHALL cover start pulsed again during SHIFT with different operands -> the first result is unaffected, and exactly one done pulse occurs.
REQ-038 A bench SHALL cover start held high in the DONE cycle -> the new operation is accepted on that edge, and the second done arrives max(shamt,1) cycles later.
REQ-039 A bench SHALL cover reset asserted mid-SHIFT (SLL, 8'hFF, shamt=7, after 3 cycles) -> outputs go to 0 immediately, no done pulse, and a later operation is correct.
